// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and parity helper for the 4-character serial transmitter.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 12;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned NUM_CHARS  = 4;
  localparam logic        START_LVL  = 1'b1;
  localparam logic        IDLE_LVL   = 1'b0;

  typedef logic [2:0]           tx_state_t;
  typedef logic [DATA_BITS-1:0] char_t;

  localparam tx_state_t StIdle   = 3'd0;
  localparam tx_state_t StStart  = 3'd1;
  localparam tx_state_t StData   = 3'd2;
  localparam tx_state_t StParity = 3'd3;
  localparam tx_state_t StStop   = 3'd4;
  localparam tx_state_t StGuard  = 3'd5;

  // Even parity over data plus parity bit.
  function automatic logic calc_parity(char_t c);
    return ^c;
  endfunction

endpackage

// File: rtl/transmisor_if.sv
// Handshake/data bundle between the message source and the transmitter.
// iErrInject exists only when TRANSMISOR_ERR_INJECT_EN is defined.
interface transmisor_if;
  import uart_pkg::*;

  logic  iCE;
  logic  iStart;
  char_t ivCarga0;
  char_t ivCarga1;
  char_t ivCarga2;
  char_t ivCarga3;
`ifdef TRANSMISOR_ERR_INJECT_EN
  logic  iErrInject;
`endif
  logic  oDatos;
  logic  oBusy;
  logic  oDone;

  modport master (
    output iCE, iStart, ivCarga0, ivCarga1, ivCarga2, ivCarga3,
`ifdef TRANSMISOR_ERR_INJECT_EN
    output iErrInject,
`endif
    input  oDatos, oBusy, oDone
  );

  modport slave (
    input  iCE, iStart, ivCarga0, ivCarga1, ivCarga2, ivCarga3,
`ifdef TRANSMISOR_ERR_INJECT_EN
    input  iErrInject,
`endif
    output oDatos, oBusy, oDone
  );

endinterface

// File: rtl/transmisor_trama.sv
// Serialises one character frame (start, 8 data LSB first, parity, stop, guard) under ce_i.
// In IDLE or GUARD, go_i selects whether another frame follows.
module transmisor_trama
  import uart_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  ce_i,
  input  logic  go_i,
  input  char_t data_i,
  input  logic  par_inv_i,
  output logic  line_o,
  output logic  char_end_o
);

  tx_state_t  state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic       line_q, line_d;

  assign char_end_o = ce_i && (state_q == StGuard);
  assign line_o     = line_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    if (ce_i) begin
      unique case (state_q)
        StIdle:   if (go_i) state_d = StStart;
        StStart: begin
          state_d = StData;
          bit_d   = 3'd0;
        end
        StData: begin
          if (bit_q == 3'(DATA_BITS - 1)) state_d = StParity;
          bit_d = bit_q + 3'd1;
        end
        StParity: state_d = StStop;
        StStop:   state_d = StGuard;
        StGuard:  state_d = go_i ? StStart : StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Line is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    line_d = IDLE_LVL;
    unique case (state_d)
      StStart:  line_d = START_LVL;
      StData:   line_d = data_i[bit_d];
      StParity: line_d = calc_parity(data_i) ^ par_inv_i;
      default:  line_d = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      bit_q   <= 3'd0;
      line_q  <= IDLE_LVL;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/transmisor.sv
// Four-character serial transmitter: captures a message, sends it through transmisor_trama.
// Define TRANSMISOR_ERR_INJECT_EN to add iErrInject, which inverts parity for a whole message.
module transmisor
  import uart_pkg::*;
(
  input logic         iClk,
  input logic         iReset_n,
  transmisor_if.slave bus
);

  char_t [NUM_CHARS-1:0] carga_q, carga_d;
  logic [1:0]            idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  capture, go, char_end, par_inv, line;

  // Capture ignores iCE; a new message needs at least one clock with busy low.
  assign capture = !busy_q && bus.iStart;
  assign go      = busy_q && (idx_q != 2'(NUM_CHARS - 1));

`ifdef TRANSMISOR_ERR_INJECT_EN
  logic err_q, err_d;
  assign err_d   = capture ? bus.iErrInject : err_q;
  assign par_inv = err_q;
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) err_q <= 1'b0;
    else           err_q <= err_d;
  end
`else
  assign par_inv = 1'b0;
`endif

  always_comb begin
    carga_d = carga_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (capture) begin
      carga_d = {bus.ivCarga3, bus.ivCarga2, bus.ivCarga1, bus.ivCarga0};
      idx_d   = 2'd0;
      busy_d  = 1'b1;
    end else if (char_end) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'(NUM_CHARS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      carga_q <= '0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      carga_q <= carga_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  transmisor_trama u_trama (
    .clk_i      (iClk),
    .rst_ni     (iReset_n),
    .ce_i       (bus.iCE),
    .go_i       (go),
    .data_i     (carga_q[idx_q]),
    .par_inv_i  (par_inv),
    .line_o     (line),
    .char_end_o (char_end)
  );

  assign bus.oDatos = line;
  assign bus.oBusy  = busy_q;
  assign bus.oDone  = done_q;

endmodule

// File: tb/tb_transmisor.sv
// Bench for transmisor: a line monitor decodes frames and checks them against queued expectations.
module tb_transmisor;
  import uart_pkg::*;

  logic iClk     = 1'b0;
  logic iReset_n = 1'b0;
  logic ce_r     = 1'b0;
  int   ce_period = 1;
  int   ce_cnt    = 0;

  transmisor_if bus();

  transmisor dut (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .bus      (bus)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    ce_cnt = (ce_cnt + 1) % ce_period;
    ce_r   = (ce_cnt == 0);
  end
  assign bus.iCE = ce_r;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   done_cnt   = 0;

  always @(posedge iClk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  // Line monitor / loopback receiver: one sample per iCE period.
  initial begin : monitor
    int         rx_cnt;
    logic [11:0] rx;
    logic       ce_s, prev_line, prev_busy;
    exp_t       e;
    rx_cnt    = 0;
    rx        = '0;
    prev_line = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(posedge iClk);
      ce_s = bus.iCE;
      #1;
      if (bus.oDone) done_cnt++;
      if (!iReset_n) begin
        rx_cnt = 0;
      end else begin
        if (!ce_s && prev_busy && bus.oBusy) check("line_hold", 32'(bus.oDatos), 32'(prev_line));
        if (ce_s) begin
          if (rx_cnt == 0) begin
            if (bus.oDatos) begin
              rx[0]  = 1'b1;
              rx_cnt = 1;
            end
          end else begin
            rx[rx_cnt] = bus.oDatos;
            rx_cnt++;
            if (rx_cnt == 12) begin
              rx_cnt = 0;
              if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_frame: got %0h expected none", rx);
              end else begin
                e = exp_q.pop_front();
                check("frame", 32'(rx[11:1]), {21'd0, 1'b0, 1'b0, e.par, e.data});
              end
            end
          end
        end
      end
      prev_line = bus.oDatos;
      prev_busy = bus.oBusy;
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d);
    bus.ivCarga0 = a;
    bus.ivCarga1 = b;
    bus.ivCarga2 = c;
    bus.ivCarga3 = d;
  endtask

  task automatic pulse_start();
    @(negedge iClk);
    bus.iStart = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
  endtask

  task automatic wait_line(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge iClk);
      #1;
      if (bus.oDatos) begin
        c = cyc;
        return;
      end
    end
    check("start_timeout", 32'(c), 32'(cyc));
  endtask

  task automatic wait_done(output int c, input bit chk_busy);
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge iClk);
      #1;
      if (bus.oDone) begin
        c = cyc;
        return;
      end
      if (chk_busy) check("busy_during_msg", 32'(bus.oBusy), 32'd1);
    end
    check("done_timeout", 32'(c), 32'(cyc));
  endtask

  initial begin : stim
    int t0, t1, d0;
    bus.iStart = 1'b0;
`ifdef TRANSMISOR_ERR_INJECT_EN
    bus.iErrInject = 1'b0;
`endif
    load(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge iClk);
    check("reset_outputs", {29'd0, bus.oDatos, bus.oBusy, bus.oDone}, 32'd0);
    iReset_n = 1'b1;
    repeat (2) @(negedge iClk);

    // Basic message, iCE every clock.
    load(8'h41, 8'h42, 8'h43, 8'h44);
    push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b1); push(8'h44, 1'b0);
    d0 = done_cnt;
    pulse_start();
    check("busy_after_capture", 32'(bus.oBusy), 32'd1);
    check("line_before_first_ce", 32'(bus.oDatos), 32'd0);
    wait_line(t0);
    wait_done(t1, 1'b1);
    check("done_latency", 32'(t1 - t0), 32'd48);
    check("busy_clear_with_done", 32'(bus.oBusy), 32'd0);
    @(posedge iClk); #1;
    check("done_single_clock", 32'(bus.oDone), 32'd0);
    repeat (5) @(negedge iClk);
    check("done_count_msg1", 32'(done_cnt - d0), 32'd1);

    // iCE every 4th clock.
    ce_period = 4;
    load(8'h07, 8'h07, 8'h07, 8'h07);
    push(8'h07, 1'b1); push(8'h07, 1'b1); push(8'h07, 1'b1); push(8'h07, 1'b1);
    d0 = done_cnt;
    pulse_start();
    wait_line(t0);
    wait_done(t1, 1'b1);
    check("done_latency_ce4", 32'(t1 - t0), 32'd192);
    @(posedge iClk); #1;
    check("done_single_clock_ce4", 32'(bus.oDone), 32'd0);
    repeat (10) @(negedge iClk);
    check("done_count_ce4", 32'(done_cnt - d0), 32'd1);
    ce_period = 1;

    // Second iStart mid-message must be ignored.
    load(8'h13, 8'h22, 8'h38, 8'h7F);
    push(8'h13, 1'b1); push(8'h22, 1'b0); push(8'h38, 1'b1); push(8'h7F, 1'b1);
    d0 = done_cnt;
    pulse_start();
    wait_line(t0);
    repeat (19) @(negedge iClk);
    load(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    bus.iStart = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
    wait_done(t1, 1'b1);
    check("done_latency_ignored_start", 32'(t1 - t0), 32'd48);
    repeat (20) @(negedge iClk);
    check("done_count_ignored_start", 32'(done_cnt - d0), 32'd1);
    check("idle_after_ignored_start", 32'(bus.oBusy), 32'd0);

    // Reset during DATA of character 2, on a data bit that is 1.
    load(8'h5A, 8'hC3, 8'hE0, 8'h0F);
    push(8'h5A, 1'b0); push(8'hC3, 1'b0); push(8'hE0, 1'b1); push(8'h0F, 1'b0);
    d0 = done_cnt;
    pulse_start();
    wait_line(t0);
    while (cyc < t0 + 31) begin
      @(posedge iClk);
      #1;
    end
    check("line_before_reset", 32'(bus.oDatos), 32'd1);
    #2;
    iReset_n = 1'b0;
    #1;
    check("async_reset_outputs", {30'd0, bus.oDatos, bus.oBusy}, 32'd0);
    check("chars_pending_at_reset", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    repeat (3) @(negedge iClk);
    iReset_n = 1'b1;
    repeat (3) @(negedge iClk);
    check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
    check("idle_after_reset", {29'd0, bus.oDatos, bus.oBusy, bus.oDone}, 32'd0);
    push(8'h5A, 1'b0); push(8'hC3, 1'b0); push(8'hE0, 1'b1); push(8'h0F, 1'b0);
    pulse_start();
    wait_line(t0);
    wait_done(t1, 1'b1);
    check("done_latency_after_reset", 32'(t1 - t0), 32'd48);

    // Loopback bytes with iStart held through completion: back-to-back messages.
    repeat (3) @(negedge iClk);
    load(8'hA5, 8'h00, 8'hFF, 8'h3C);
    for (int k = 0; k < 2; k++) begin
      push(8'hA5, 1'b0); push(8'h00, 1'b0); push(8'hFF, 1'b0); push(8'h3C, 1'b0);
    end
    d0 = done_cnt;
    @(negedge iClk);
    bus.iStart = 1'b1;
    wait_line(t0);
    wait_done(t1, 1'b1);
    check("done_latency_held", 32'(t1 - t0), 32'd48);
    check("idle_clock_between_msgs", 32'(bus.oBusy), 32'd0);
    @(posedge iClk); #1;
    check("recapture_after_idle", 32'(bus.oBusy), 32'd1);
    @(negedge iClk);
    bus.iStart = 1'b0;
    wait_line(t0);
    wait_done(t1, 1'b1);
    check("done_latency_second", 32'(t1 - t0), 32'd48);
    repeat (5) @(negedge iClk);
    check("done_count_held", 32'(done_cnt - d0), 32'd2);

`ifdef TRANSMISOR_ERR_INJECT_EN
    load(8'h41, 8'h41, 8'h41, 8'h41);
    push(8'h41, 1'b1); push(8'h41, 1'b1); push(8'h41, 1'b1); push(8'h41, 1'b1);
    bus.iErrInject = 1'b1;
    pulse_start();
    bus.iErrInject = 1'b0;
    wait_line(t0);
    wait_done(t1, 1'b1);
    check("done_latency_err", 32'(t1 - t0), 32'd48);
`endif

    repeat (5) @(negedge iClk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/transmisor.md
TRANSMISOR -- requirements
Module: transmisor

Interface
REQ-001 iClk  input  1  single system clock; all state updates on rising edge.
REQ-002 iReset_n  input  1  reset, asynchronous, active-low.
REQ-003 iCE  input  1  bit-period enable; line state advances only on clocks with iCE=1.
REQ-004 iStart  input  1  request to send one 4-character message; sampled every clock.
REQ-005 ivCarga0..ivCarga3  input  8 each  characters 0..3, sent in index order 0,1,2,3.
REQ-006 oDatos  output  1  serial line, registered; idle level 0.
REQ-007 oBusy  output  1  high from the capture clock until the message completes.
REQ-008 oDone  output  1  one-clock pulse when the last bit period of character 3 ends.

Function
REQ-009 Character frame SHALL be 12 bit periods: start=1, D0..D7 (LSB first), parity, stop=0, guard=0.
REQ-010 Parity bit SHALL equal the XOR of D7..D0 (even parity over data plus parity).
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, GUARD; each non-IDLE state lasts one iCE period, except DATA, which lasts 8.
REQ-012 In IDLE with iStart=1, the block SHALL capture all four bytes into internal registers and set oBusy on the next clock, independent of iCE.
REQ-013 The first iCE clock after capture SHALL enter START and drive oDatos=1; latency is capture clock + first iCE.
REQ-014 A 3-bit bit counter SHALL index DATA bits 0..7; DATA->PARITY on the iCE where the counter equals 7.
REQ-015 A 2-bit character index SHALL advance on GUARD exit; GUARD->START if index<3, GUARD->IDLE if index==3 (wraps to 0).
REQ-016 On GUARD->IDLE, the block SHALL pulse oDone for exactly that clock and clear oBusy on the same edge.
REQ-017 iStart while oBusy=1 SHALL be ignored; captured bytes SHALL not change mid-message.
REQ-018 iStart held high through the completion clock SHALL start a new capture on the first clock after IDLE is re-entered (minimum one IDLE clock between messages).
REQ-019 With iCE=0, oDatos, state, counters and oBusy SHALL hold their values.
REQ-020 A complete message SHALL take exactly 48 iCE periods after capture.

Reset
REQ-021 iReset_n=0 SHALL force the following immediately, regardless of iCE or state: IDLE, oDatos=0, oBusy=0, oDone=0, counters=0, captured bytes=0.
REQ-022 Reset mid-frame SHALL abort the message with no oDone pulse; the line returns to 0, which a peer receiver reads as idle.

Configuration
REQ-023 Macro TRANSMISOR_ERR_INJECT_EN defined: add input iErrInject (1 bit), sampled at capture; if 1, the parity bit of every character in that message SHALL be inverted.
REQ-024 Macro TRANSMISOR_ERR_INJECT_EN undefined: the port SHALL be absent and parity SHALL always follow REQ-010.

Structure
REQ-025 Shared package uart_pkg SHALL hold FRAME_BITS=12, DATA_BITS=8, NUM_CHARS=4, START_LVL=1, IDLE_LVL=0 and the FSM state encoding.
REQ-026 Optional sub-module transmisor_trama SHALL serialise one byte (START..GUARD) under iCE; the top level owns capture, character index, oBusy and oDone.

Verification
REQ-027 Bytes 0x41,0x42,0x43,0x44, iCE=1 every clock, iStart pulse -> char 0 line sequence 1,1,0,0,0,0,0,1,0,0,0,0; oDone exactly 48 clocks after the first START.
REQ-028 Byte 0x07, iCE every 4th clock -> each bit held 4 clocks; parity=1; oBusy high throughout; oDone single clock.
REQ-029 Second iStart pulse at iCE period 20 -> ignored; transmitted bytes unchanged; one oDone only.
REQ-030 iReset_n asserted in the DATA state of char 2 -> oDatos=0 and oBusy=0 asynchronously; no oDone; a following iStart sends a full 48-period message.
REQ-031 Loopback into the 4-character receiver with bytes 0xA5,0x00,0xFF,0x3C -> receiver outputs equal the sent bytes in order.
REQ-032 With TRANSMISOR_ERR_INJECT_EN and iErrInject=1, byte 0x41 -> parity bit 1; loopback receiver rejects the characters.
